pkt_assembler: RTL and testbench

PKT_ASSEMBLER -- requirements
Module: pkt_assembler

---
 rtl/pkt_assembler_if.sv | 29 ++
 rtl/pkt_assembler.sv | 86 ++++++++
 tb/tb_pkt_assembler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_assembler_if.sv
// Bundle of source-beat and assembled-packet signals shared between the
// packet assembler (slave) and its environment (master).
interface pkt_assembler_if #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 8
);
    logic                      src_valid;
    logic [DATA_W-1:0]         src_data;
    logic [3:0]                src_dest;
    logic                      src_last;
    logic                      src_ready;
    logic                      en_gen;
    logic                      packet_valid;
    logic [MAX_LEN*DATA_W-1:0] pkt_payload;
    logic [3:0]                pkt_dest;
    logic [3:0]                count;
    logic [DATA_W-1:0]         pkt_chk;
    logic                      pkt_trunc;

    modport slave (
        input  src_valid, src_data, src_dest, src_last, en_gen,
        output src_ready, packet_valid, pkt_payload, pkt_dest, count, pkt_chk, pkt_trunc
    );

    modport master (
        output src_valid, src_data, src_dest, src_last, en_gen,
        input  src_ready, packet_valid, pkt_payload, pkt_dest, count, pkt_chk, pkt_trunc
    );
endinterface

// File: rtl/pkt_assembler.sv
// Collects source beats into a packet of up to MAX_LEN beats, then holds it
// with destination, beat count and XOR checksum until the consumer takes it.
module pkt_assembler #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 8
) (
    input  logic           clk,
    input  logic           reset,
    pkt_assembler_if.slave bus
);
    typedef enum logic {COLLECT, HOLD} state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] beat_reg [MAX_LEN];
    logic [3:0]        count_reg;
    logic [DATA_W-1:0] chk_reg;
    logic [3:0]        dest_reg;
    logic              trunc_reg;
    logic              ready_reg;
    logic              valid_reg;

    logic              last_slot;
    assign last_slot = (count_reg == 4'(MAX_LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= COLLECT;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            count_reg <= '0;
            chk_reg   <= '0;
            dest_reg  <= '0;
            trunc_reg <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) beat_reg[i] <= '0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (bus.src_valid) begin
                        // Destination belongs to the packet, so only the opening beat sets it.
                        if (count_reg == 4'd0) dest_reg <= bus.src_dest;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (count_reg == 4'(i)) beat_reg[i] <= bus.src_data;
                        end
                        count_reg <= count_reg + 4'd1;
                        chk_reg   <= chk_reg ^ bus.src_data;
                        if (bus.src_last || last_slot) begin
                            state_reg <= HOLD;
                            ready_reg <= 1'b0;
                            valid_reg <= 1'b1;
                            trunc_reg <= ~bus.src_last;
                        end
                    end
                end
                HOLD: begin
                    if (bus.en_gen) begin
                        state_reg <= COLLECT;
                        ready_reg <= 1'b1;
                        valid_reg <= 1'b0;
                        count_reg <= '0;
                        chk_reg   <= '0;
                        trunc_reg <= 1'b0;
                        for (int i = 0; i < MAX_LEN; i++) beat_reg[i] <= '0;
                    end
                end
                default: begin
                    state_reg <= COLLECT;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_payload
            assign bus.pkt_payload[gi*DATA_W +: DATA_W] = beat_reg[gi];
        end
    endgenerate

    assign bus.src_ready    = ready_reg;
    assign bus.packet_valid = valid_reg;
    assign bus.pkt_dest     = dest_reg;
    assign bus.count        = count_reg;
    assign bus.pkt_chk      = chk_reg;
    assign bus.pkt_trunc    = trunc_reg;
endmodule

// File: tb/tb_pkt_assembler.sv
// Scoreboard bench for pkt_assembler: each driven beat feeds a packet model,
// closed packets are queued and compared when the DUT presents them.
module tb_pkt_assembler;
    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 8;
    localparam int PW      = DATA_W * MAX_LEN;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pkt_assembler_if #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) bus ();

    pkt_assembler #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [PW-1:0]     payload;
        logic [3:0]        dest;
        logic [3:0]        cnt;
        logic [DATA_W-1:0] chk;
        logic              trunc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [PW-1:0]     m_payload;
    int                m_cnt;
    logic [DATA_W-1:0] m_chk;
    logic [3:0]        m_dest;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_payload = '0;
        m_cnt     = 0;
        m_chk     = '0;
    endtask

    // Drive one beat; returns #1 after the accepting edge.
    task automatic beat(input logic [7:0] d, input logic [3:0] dst, input logic last);
        bus.src_valid = 1'b1;
        bus.src_data  = d;
        bus.src_dest  = dst;
        bus.src_last  = last;
        check("ready_pre", bus.src_ready, 1);
        @(posedge clk);
        #1;
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        if (m_cnt == 0) m_dest = dst;
        m_payload[m_cnt*DATA_W +: DATA_W] = d;
        m_chk = m_chk ^ d;
        m_cnt++;
        $display("beat data=%02h dest=%0h last=%0b", d, dst, last);
        if (last || m_cnt == MAX_LEN) begin
            exp_q.push_back('{m_payload, m_dest, 4'(m_cnt), m_chk, ~last});
            model_clear();
        end
    endtask

    // Compare the held packet, keep it for 'hold' cycles, then release it.
    task automatic take(input int hold, input logic drive_valid);
        exp_t e;
        int   waited = 0;
        logic [PW-1:0] p0;
        while (!bus.packet_valid && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("pv_latency", waited, 0);
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("payload", bus.pkt_payload, e.payload);
        check("dest", bus.pkt_dest, e.dest);
        check("count", bus.count, e.cnt);
        check("chk", bus.pkt_chk, e.chk);
        check("trunc", bus.pkt_trunc, e.trunc);
        check("ready_hold", bus.src_ready, 0);
        $display("packet dest=%0h count=%0d chk=%02h trunc=%0b payload=%0h",
                 bus.pkt_dest, bus.count, bus.pkt_chk, bus.pkt_trunc, bus.pkt_payload);
        p0 = bus.pkt_payload;
        bus.src_valid = drive_valid;
        bus.src_data  = 8'hEE;
        bus.src_dest  = 4'hC;
        repeat (hold) @(posedge clk);
        #1;
        if (hold > 0) begin
            check("hold_pv", bus.packet_valid, 1);
            check("hold_ready", bus.src_ready, 0);
            check("hold_payload", bus.pkt_payload, p0);
            check("hold_count", bus.count, e.cnt);
            check("hold_chk", bus.pkt_chk, e.chk);
        end
        bus.en_gen = 1'b1;
        @(posedge clk);
        #1;
        bus.en_gen    = 1'b0;
        bus.src_valid = 1'b0;
        check("ready_after", bus.src_ready, 1);
        check("pv_after", bus.packet_valid, 0);
        check("cnt_clr", bus.count, 0);
        check("chk_clr", bus.pkt_chk, 0);
        check("payload_clr", bus.pkt_payload, 0);
        check("trunc_clr", bus.pkt_trunc, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pv"}, bus.packet_valid, 0);
        check({tag, "_ready"}, bus.src_ready, 1);
        check({tag, "_payload"}, bus.pkt_payload, 0);
        check({tag, "_dest"}, bus.pkt_dest, 0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_chk"}, bus.pkt_chk, 0);
        check({tag, "_trunc"}, bus.pkt_trunc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.src_dest  = '0;
        bus.src_last  = 1'b0;
        bus.en_gen    = 1'b0;
        model_clear();
        m_dest = '0;
        #12;
        check_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // en_gen while collecting with no beats has no effect
        bus.en_gen = 1'b1;
        @(posedge clk);
        #1;
        bus.en_gen = 1'b0;
        check("collect_en_ready", bus.src_ready, 1);
        check("collect_en_pv", bus.packet_valid, 0);
        check("collect_en_cnt", bus.count, 0);

        // three beats, dest 5
        beat(8'h11, 4'd5, 1'b0);
        beat(8'h22, 4'd5, 1'b0);
        beat(8'h33, 4'd5, 1'b1);
        check("p1_chk_lit", bus.pkt_chk, 8'h00);
        check("p1_payload_lit", bus.pkt_payload, 64'h0000_0000_0033_2211);
        take(0, 1'b0);

        // ten beats: truncated at MAX_LEN, remainder forms second packet
        for (int i = 1; i <= 10; i++) begin
            beat(8'(i), 4'(i), i == 10);
            if (i == MAX_LEN) begin
                check("trunc_chk_lit", bus.pkt_chk, 8'h08);
                take(0, 1'b0);
            end
        end
        check("p2b_chk_lit", bus.pkt_chk, 8'h03);
        take(0, 1'b0);

        // long hold with src_valid asserted
        beat(8'h77, 4'd1, 1'b1);
        take(20, 1'b1);

        // single beat
        beat(8'hA5, 4'hF, 1'b1);
        take(0, 1'b0);

        // dest changes mid-packet
        beat(8'h01, 4'd3, 1'b0);
        beat(8'h02, 4'd9, 1'b1);
        take(0, 1'b0);

        // exactly MAX_LEN beats with last on the final one
        for (int i = 0; i < MAX_LEN; i++) beat(8'(8'h40 + i), 4'd7, i == MAX_LEN - 1);
        take(1, 1'b0);

        // asynchronous reset mid-packet
        beat(8'h5A, 4'd4, 1'b0);
        beat(8'h6B, 4'd4, 1'b0);
        model_clear();
        #2;
        reset = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_mid_nopkt", bus.packet_valid, 0);
        beat(8'hC3, 4'd6, 1'b1);
        check("rst_mid_cnt_lit", bus.count, 1);
        take(0, 1'b0);

        // asynchronous reset while holding
        beat(8'h99, 4'd2, 1'b1);
        void'(exp_q.pop_back());
        #2;
        reset = 1'b0;
        #1;
        check_zero("rst_hold");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_nopkt", bus.packet_valid, 0);

        // random packets, variable consumer delay
        for (int p = 0; p < 8; p++) begin
            int len;
            len = $urandom_range(1, 11);
            for (int b = 0; b < len; b++) begin
                beat(8'($urandom), 4'($urandom), b == len - 1);
                if (exp_q.size() > 0) take($urandom_range(0, 2), 1'($urandom));
            end
        end

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
